// File: rtl/mult_stream_pkg.sv
// Shared defaults and helpers for the streaming multiply stage.
// Holds count-width sizing and the saturation limit used by the optional statistics counters.
package mult_stream_pkg;

  localparam int AW_DEF         = 8;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int MUL_LAT_DEF    = 2;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  // An occupancy count must represent 0..2^depth_log2 inclusive, hence the extra bit.
  function automatic int cnt_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered read port: a read registers data and pulses vld_o one edge later.
// Writes while full are dropped (over_o pulses) and reads while empty are ignored (under_o pulses).
module sync_fifo
  import mult_stream_pkg::*;
#(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [W-1:0]          din_i,
  input  logic                  rd_i,
  output logic [W-1:0]          dout_o,
  output logic                  vld_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  over_o,
  output logic                  under_o
);

  localparam int              CW    = cnt_w(DEPTH_LOG2);
  localparam logic [CW-1:0]   DEPTH = CW'(2 ** DEPTH_LOG2);

  logic [W-1:0]          mem_q [2 ** DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [W-1:0]          dout_q, dout_d;
  logic                  vld_q, over_q, under_q;
  logic                  wr_ok, rd_ok;

  // FULL/EMPTY come straight from the registered count, so they reflect the state before the edge.
  assign full_o  = (count_q == DEPTH);
  assign empty_o = (count_q == '0);
  assign wr_ok   = wr_i & ~full_o;
  assign rd_ok   = rd_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (wr_ok) begin
      wptr_d = wptr_q + DEPTH_LOG2'(1);
    end
    if (rd_ok) begin
      rptr_d = rptr_q + DEPTH_LOG2'(1);
      dout_d = mem_q[rptr_q];
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      vld_q   <= rd_ok;
      over_q  <= wr_i & full_o;
      under_q <= rd_i & empty_o;
    end
  end

  assign dout_o  = dout_q;
  assign vld_o   = vld_q;
  assign count_o = count_q;
  assign over_o  = over_q;
  assign under_o = under_q;

endmodule

// File: rtl/mult_stream_pipe.sv
// Input FIFO -> MUL_LAT-stage multiplier -> output FIFO; WR-to-VALID is MUL_LAT+3 edges with RD high.
// Credit on out_count+inflight stalls only the admission pop; MSP_STAT_EN adds RESULT_CNT/STALL_CNT.
module mult_stream_pipe
  import mult_stream_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int MUL_LAT    = MUL_LAT_DEF,
  parameter int SIGNED     = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [2*AW-1:0] DIN,
  input  logic            WR,
  output logic            FULL,
  output logic            OVER,
  input  logic            RD,
  output logic [2*AW-1:0] DOUT,
  output logic            VALID,
  output logic            EMPTY,
  output logic            UNDER,
  output logic [31:0]     RESULT_CNT,
  output logic [31:0]     STALL_CNT
);

  localparam int DW = 2 * AW;
  localparam int CW = cnt_w(DEPTH_LOG2);

  logic [DW-1:0]      op_dat;
  logic               op_vld;
  logic               in_empty;
  logic [CW-1:0]      in_count;
  logic               in_under;
  logic [CW-1:0]      out_count;
  logic               out_full;
  logic               out_over;
  logic [DW-1:0]      a_ext, b_ext, prod_d;
  logic [DW-1:0]      prod_q [MUL_LAT];
  logic [MUL_LAT-1:0] pvld_q;
  logic [31:0]        inflight;
  logic               credit_ok, pop;

  sync_fifo #(
    .W          (DW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ififo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .wr_i    (WR),
    .din_i   (DIN),
    .rd_i    (pop),
    .dout_o  (op_dat),
    .vld_o   (op_vld),
    .full_o  (FULL),
    .empty_o (in_empty),
    .count_o (in_count),
    .over_o  (OVER),
    .under_o (in_under)
  );

  // Credit covers every word already committed downstream: the read stage plus all multiplier stages.
  always_comb begin
    inflight = 32'(op_vld);
    for (int k = 0; k < MUL_LAT; k++) begin
      inflight = inflight + 32'(pvld_q[k]);
    end
  end

  assign credit_ok = (32'(out_count) + inflight) < (32'd1 << DEPTH_LOG2);
  assign pop       = ~in_empty & credit_ok;

  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{AW{op_dat[DW-1]}}, op_dat[DW-1:AW]};
      b_ext = {{AW{op_dat[AW-1]}}, op_dat[AW-1:0]};
    end else begin
      a_ext = {{AW{1'b0}}, op_dat[DW-1:AW]};
      b_ext = {{AW{1'b0}}, op_dat[AW-1:0]};
    end
  end

  // Low DW bits of the DW-wide product are exact for both signed and unsigned operands.
  assign prod_d = a_ext * b_ext;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pvld_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      pvld_q[0] <= op_vld;
      prod_q[0] <= prod_d;
      for (int k = 1; k < MUL_LAT; k++) begin
        pvld_q[k] <= pvld_q[k-1];
        prod_q[k] <= prod_q[k-1];
      end
    end
  end

  sync_fifo #(
    .W          (DW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ofifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .wr_i    (pvld_q[MUL_LAT-1]),
    .din_i   (prod_q[MUL_LAT-1]),
    .rd_i    (RD),
    .dout_o  (DOUT),
    .vld_o   (VALID),
    .full_o  (out_full),
    .empty_o (EMPTY),
    .count_o (out_count),
    .over_o  (out_over),
    .under_o (UNDER)
  );

`ifdef MSP_STAT_EN
  logic [31:0] result_cnt_q, result_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    result_cnt_d = result_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (pvld_q[MUL_LAT-1] && (result_cnt_q != CNT_SAT)) begin
      result_cnt_d = result_cnt_q + 32'd1;
    end
    if (!in_empty && !credit_ok && (stall_cnt_q != CNT_SAT)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      result_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      result_cnt_q <= result_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign RESULT_CNT = result_cnt_q;
  assign STALL_CNT  = stall_cnt_q;
`else
  assign RESULT_CNT = 32'h0;
  assign STALL_CNT  = 32'h0;
`endif

  // Status the top has no use for: input underflow cannot occur and output overflow is prevented by credit.
  logic unused_status;
  assign unused_status = &{1'b0, in_under, in_count, out_full, out_over};

endmodule
